// File: rtl/adder_pkg.sv
// Shared constants and the 4-bit lookahead carry function used by both
// levels of the carry-lookahead adder.
package adder_pkg;

  localparam int ADDER_N_DEF = 32;
  localparam int CLA_GROUP   = 4;

  // Returns carries c[0..4] for a 4-bit group; c[4] is the group carry-out,
  // so calling with c0=0 yields the group generate in bit 4.
  function automatic logic [4:0] cla4_carries(input logic [3:0] g,
                                               input logic [3:0] p,
                                               input logic       c0);
    logic [4:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

endpackage

// File: rtl/adder_cla.sv
// Two-level carry-lookahead adder core: 4-bit groups feeding a second-level
// lookahead over group generate/propagate, purely combinational.
module adder_cla
  import adder_pkg::*;
#(
  parameter int N = ADDER_N_DEF
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  localparam int NG = N / CLA_GROUP;
  localparam int NB = (NG + CLA_GROUP - 1) / CLA_GROUP;

  logic [N-1:0]           g;
  logic [N-1:0]           p;
  logic [N-1:0]           c;
  logic [NB*CLA_GROUP-1:0] gg;
  logic [NB*CLA_GROUP-1:0] gp;
  logic [NB*CLA_GROUP:0]   gc;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    logic [4:0] r;
    r  = '0;
    gg = '0;
    gp = '0;
    for (int j = 0; j < NG; j++) begin
      r     = cla4_carries(g[4*j +: 4], p[4*j +: 4], 1'b0);
      gg[j] = r[4];
      gp[j] = &p[4*j +: 4];
    end
  end

  // Padding groups have gg=gp=0, so they never disturb the real carries;
  // blocks of four groups chain through their block carry-out.
  always_comb begin
    logic [4:0] r;
    logic       cb;
    r  = '0;
    gc = '0;
    cb = ci;
    for (int k = 0; k < NB; k++) begin
      r             = cla4_carries(gg[4*k +: 4], gp[4*k +: 4], cb);
      gc[4*k +: 5]  = r;
      cb            = r[4];
    end
  end

  always_comb begin
    logic [4:0] r;
    r = '0;
    c = '0;
    for (int j = 0; j < NG; j++) begin
      r            = cla4_carries(g[4*j +: 4], p[4*j +: 4], gc[j]);
      c[4*j +: 4]  = r[3:0];
    end
  end

  assign s  = p ^ c;
  assign co = gc[NG];

endmodule

// File: rtl/adder_rca.sv
// Ripple-carry adder core: N chained full adders, purely combinational.
module adder_rca
  import adder_pkg::*;
#(
  parameter int N = ADDER_N_DEF
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  always_comb begin
    logic c;
    c = ci;
    s = '0;
    for (int i = 0; i < N; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/adder_cla_rca.sv
// Dual-architecture adder: RCA and CLA cores computed in parallel, results
// registered together with a cross-check flag.
module adder_cla_rca
  import adder_pkg::*;
#(
  parameter int N = ADDER_N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s_rca,
  output logic         co_rca,
  output logic [N-1:0] s_cla,
  output logic         co_cla,
  output logic         mismatch
);

  if ((N % CLA_GROUP) != 0 || N < CLA_GROUP) begin : g_bad_width
    $error("adder_cla_rca: N must be a positive multiple of 4");
  end

  logic [N-1:0] s_rca_c;
  logic [N-1:0] s_cla_c;
  logic         co_rca_c;
  logic         co_cla_c;
  logic         mismatch_c;

  adder_rca #(.N(N)) u_rca (
    .a  (a),
    .b  (b),
    .ci (ci),
    .s  (s_rca_c),
    .co (co_rca_c)
  );

  adder_cla #(.N(N)) u_cla (
    .a  (a),
    .b  (b),
    .ci (ci),
    .s  (s_cla_c),
    .co (co_cla_c)
  );

  assign mismatch_c = ({co_rca_c, s_rca_c} != {co_cla_c, s_cla_c});

  always_ff @(posedge clk) begin
    if (rst) begin
      s_rca    <= '0;
      co_rca   <= 1'b0;
      s_cla    <= '0;
      co_cla   <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      s_rca    <= s_rca_c;
      co_rca   <= co_rca_c;
      s_cla    <= s_cla_c;
      co_cla   <= co_cla_c;
      mismatch <= mismatch_c;
    end
  end

endmodule

// File: tb/tb_adder_cla_rca.sv
// Self-checking bench for adder_cla_rca at N=32, 8 and 4 against an
// arithmetic a+b+ci reference model.
module tb_adder_cla_rca;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [31:0] a32, b32, s_rca32, s_cla32;
  logic        ci32, co_rca32, co_cla32, mm32;
  logic [7:0]  a8, b8, s_rca8, s_cla8;
  logic        ci8, co_rca8, co_cla8, mm8;
  logic [3:0]  a4, b4, s_rca4, s_cla4;
  logic        ci4, co_rca4, co_cla4, mm4;

  int n_checks = 0;
  int n_fail   = 0;

  adder_cla_rca #(.N(32)) dut32 (
    .clk(clk), .rst(rst), .a(a32), .b(b32), .ci(ci32),
    .s_rca(s_rca32), .co_rca(co_rca32), .s_cla(s_cla32), .co_cla(co_cla32),
    .mismatch(mm32)
  );
  adder_cla_rca #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .ci(ci8),
    .s_rca(s_rca8), .co_rca(co_rca8), .s_cla(s_cla8), .co_cla(co_cla8),
    .mismatch(mm8)
  );
  adder_cla_rca #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .ci(ci4),
    .s_rca(s_rca4), .co_rca(co_rca4), .s_cla(s_cla4), .co_cla(co_cla4),
    .mismatch(mm4)
  );

  // Observed bundles: {mismatch, co_rca, s_rca, co_cla, s_cla}
  wire [66:0] obs32 = {mm32, co_rca32, s_rca32, co_cla32, s_cla32};
  wire [18:0] obs8  = {mm8, co_rca8, s_rca8, co_cla8, s_cla8};
  wire [10:0] obs4  = {mm4, co_rca4, s_rca4, co_cla4, s_cla4};

  function automatic logic [66:0] exp32(input logic [31:0] x, input logic [31:0] y,
                                        input logic c);
    logic [32:0] r;
    r = {1'b0, x} + {1'b0, y} + {32'b0, c};
    return {1'b0, r, r};
  endfunction

  function automatic logic [18:0] exp8(input logic [7:0] x, input logic [7:0] y,
                                       input logic c);
    logic [8:0] r;
    r = {1'b0, x} + {1'b0, y} + {8'b0, c};
    return {1'b0, r, r};
  endfunction

  function automatic logic [10:0] exp4(input logic [3:0] x, input logic [3:0] y,
                                       input logic c);
    logic [4:0] r;
    r = {1'b0, x} + {1'b0, y} + {4'b0, c};
    return {1'b0, r, r};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    a32 = 32'hFFFF_FFFF; b32 = 32'h1; ci32 = 1'b0;
    a8 = 8'hFF; b8 = 8'h1; ci8 = 1'b0;
    a4 = 4'hF; b4 = 4'h1; ci4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (obs32 !== 67'h0) begin
      n_fail++;
      $display("FAIL reset32 got %h want %h", obs32, 67'h0);
    end
    n_checks++;
    if (obs8 !== 19'h0) begin
      n_fail++;
      $display("FAIL reset8 got %h want %h", obs8, 19'h0);
    end
    n_checks++;
    if (obs4 !== 11'h0) begin
      n_fail++;
      $display("FAIL reset4 got %h want %h", obs4, 11'h0);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (obs32 !== {1'b0, 33'h1_0000_0000, 33'h1_0000_0000}) begin
      n_fail++;
      $display("FAIL reset_release32 got %h want %h", obs32,
               {1'b0, 33'h1_0000_0000, 33'h1_0000_0000});
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [4] = '{32'h0000_0005, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_000F};
    logic [31:0] tb [4] = '{32'h0000_0003, 32'h8000_0000, 32'h0000_0000, 32'h0000_0001};
    logic        tc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [32:0] tr [4] = '{33'h0_0000_0008, 33'h1_0000_0000, 33'h1_0000_0000,
                            33'h0_0000_0010};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a32 = ta[i]; b32 = tb[i]; ci32 = tc[i];
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (obs32 !== {1'b0, tr[i], tr[i]}) begin
        n_fail++;
        $display("FAIL directed32[%0d] got %h want %h", i, obs32, {1'b0, tr[i], tr[i]});
      end
    end
  endtask

  task automatic test_group_boundaries();
    // A single 1 plus a run of ones ending at each group edge forces the
    // carry across that boundary.
    for (int k = 1; k < 8; k++) begin
      logic [31:0] x;
      logic [66:0] e;
      x = (32'h1 << (4 * k)) - 32'h1;
      @(negedge clk);
      a32 = x; b32 = 32'h0; ci32 = 1'b1;
      e = exp32(x, 32'h0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (obs32 !== e) begin
        n_fail++;
        $display("FAIL group_edge32[%0d] got %h want %h", k, obs32, e);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 512; i++) begin
      logic [66:0] e;
      @(negedge clk);
      a32 = $urandom(); b32 = $urandom(); ci32 = 1'($urandom_range(0, 1));
      e = exp32(a32, b32, ci32);
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (obs32 !== e) begin
        n_fail++;
        $display("FAIL random32[%0d] got %h want %h", i, obs32, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [66:0] e_prev;
    bit          have_prev;
    have_prev = 1'b0;
    e_prev    = '0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (have_prev) begin
        n_checks++;
        if (obs32 !== e_prev) begin
          n_fail++;
          $display("FAIL b2b32[%0d] got %h want %h", i, obs32, e_prev);
        end
      end
      rst  = (i == 12);
      a32  = $urandom(); b32 = $urandom(); ci32 = 1'($urandom_range(0, 1));
      e_prev    = rst ? 67'h0 : exp32(a32, b32, ci32);
      have_prev = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    n_checks++;
    if (obs32 !== e_prev) begin
      n_fail++;
      $display("FAIL b2b32_last got %h want %h", obs32, e_prev);
    end
    rst = 1'b0;
  endtask

  task automatic test_param_sweep();
    logic [7:0] a8t [5] = '{8'h05, 8'h80, 8'hFF, 8'h0F, 8'hFF};
    logic [7:0] b8t [5] = '{8'h03, 8'h80, 8'h00, 8'h01, 8'h01};
    logic       c8t [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [8:0] r8t [5] = '{9'h008, 9'h100, 9'h100, 9'h010, 9'h100};
    logic [3:0] a4t [5] = '{4'hF, 4'h5, 4'h8, 4'h0, 4'h7};
    logic [3:0] b4t [5] = '{4'h1, 4'h3, 4'h8, 4'h0, 4'h8};
    logic       c4t [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [4:0] r4t [5] = '{5'h10, 5'h08, 5'h10, 5'h01, 5'h10};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a8 = a8t[i]; b8 = b8t[i]; ci8 = c8t[i];
      a4 = a4t[i]; b4 = b4t[i]; ci4 = c4t[i];
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (obs8 !== {1'b0, r8t[i], r8t[i]}) begin
        n_fail++;
        $display("FAIL directed8[%0d] got %h want %h", i, obs8, {1'b0, r8t[i], r8t[i]});
      end
      n_checks++;
      if (obs4 !== {1'b0, r4t[i], r4t[i]}) begin
        n_fail++;
        $display("FAIL directed4[%0d] got %h want %h", i, obs4, {1'b0, r4t[i], r4t[i]});
      end
    end
    for (int i = 0; i < 64; i++) begin
      logic [18:0] e8;
      logic [10:0] e4;
      @(negedge clk);
      a8 = 8'($urandom()); b8 = 8'($urandom()); ci8 = 1'($urandom_range(0, 1));
      a4 = 4'($urandom()); b4 = 4'($urandom()); ci4 = 1'($urandom_range(0, 1));
      e8 = exp8(a8, b8, ci8);
      e4 = exp4(a4, b4, ci4);
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (obs8 !== e8) begin
        n_fail++;
        $display("FAIL random8[%0d] got %h want %h", i, obs8, e8);
      end
      n_checks++;
      if (obs4 !== e4) begin
        n_fail++;
        $display("FAIL random4[%0d] got %h want %h", i, obs4, e4);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    a32 = '0; b32 = '0; ci32 = 1'b0;
    a8 = '0; b8 = '0; ci8 = 1'b0;
    a4 = '0; b4 = '0; ci4 = 1'b0;
    test_reset();
    test_directed();
    test_group_boundaries();
    test_random();
    test_back_to_back();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
